// File: rtl/frame_clear_sequencer.sv
// Clear-screen sequencer: sweeps the frame buffer with a latched colour while
// stalling the pipeline, and shares the frame-buffer write port with pipeline writes.
module frame_clear_sequencer #(
    parameter int ADDR_W     = 17,
    parameter int PIXEL_W    = 8,
    parameter int NUM_PIXELS = 76800,
    parameter int BASE_ADDR  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [PIXEL_W-1:0] color,
    input  logic               pipe_we,
    input  logic [ADDR_W-1:0]  pipe_addr,
    input  logic [PIXEL_W-1:0] pipe_wdata,
    output logic               fb_we,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [PIXEL_W-1:0] fb_wdata,
    output logic               stall,
    output logic               busy,
    output logic               done
);
    localparam int CNT_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam logic [CNT_W-1:0]  LAST = CNT_W'(NUM_PIXELS - 1);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [PIXEL_W-1:0] color_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            color_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        color_q <= color;
                        count   <= '0;
                        state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    // Count holds at the last pixel so it never needs a spare bit.
                    if (count == LAST) state <= DONE;
                    else               count <= count + 1'b1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        fb_we    = 1'b0;
        fb_addr  = '0;
        fb_wdata = '0;
        stall    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                // A start in the same cycle claims the port; the pipeline write is lost.
                stall = start;
                if (pipe_we && !start) begin
                    fb_we    = 1'b1;
                    fb_addr  = pipe_addr;
                    fb_wdata = pipe_wdata;
                end
            end
            CLEAR: begin
                fb_we    = 1'b1;
                fb_addr  = BASE + ADDR_W'(count);
                fb_wdata = color_q;
                stall    = 1'b1;
                busy     = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always @(posedge clk) begin
        if (!rst && state == IDLE)
            assert (!(start && pipe_we))
            else $warning("start and pipe_we asserted together; pipeline write dropped");
    end
endmodule
